uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter frame port among p_REQUESTERS clients using round-robin arbitration.
- Captures the winning client's data word and issues a one-cycle start pulse to the transmitter.
- Waits for the transmitter's frame-done pulse, then enforces an inter-frame idle gap before the next grant.
- Supports bounded multi-frame locking and a done-timeout, so one client cannot starve the others and a hung transmitter cannot deadlock the scheduler.

Parameters:
- p_REQUESTERS, 4, number of clients (2..16).
- p_DATA_BITS, 8, data word width per frame (1..16).
- p_GAP_CYCLES, 2, idle cycles inserted after each frame (0 allowed).
- p_MAX_LOCK, 3, maximum consecutive frames granted to one locking client (>=1).
- p_TIMEOUT, 1000, cycles to wait for i_tx_done before aborting (>=2).

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- iv_req  in  p_REQUESTERS  per-client request; held with data until that client's ack.
- iv_lock  in  p_REQUESTERS  per-client lock; keeps the grant for the following frame.
- iv_data  in  p_REQUESTERS*p_DATA_BITS  packed client data; client k uses bits [k*p_DATA_BITS +: p_DATA_BITS].
- ov_ack  out  p_REQUESTERS  one-hot, one-cycle pulse: client data captured.
- ov_grant  out  p_REQUESTERS  one-hot owner of the current frame; 0 when idle.
- ov_tx_data  out  p_DATA_BITS  word to the transmitter; stable from start until the next capture.
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- i_tx_done  in  1  one-cycle pulse from the transmitter: frame fully sent.
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  one-cycle pulse when a frame is aborted on timeout.

Behaviour:
- Reset: all outputs 0, round-robin pointer = 0, lock count = 0, state = IDLE. Reset mid-frame aborts silently: no ack, no timeout pulse.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE, cycle T with |iv_req:
  - Select the first k with iv_req[k]=1, searching from the pointer upward and wrapping modulo p_REQUESTERS.
  - At T+1: state = START; ov_tx_data = client k's data; ov_ack[k] = 1; ov_grant[k] = 1; o_tx_start = 1.
  - Latency from request to start is 1 cycle.
- START: lasts 1 cycle, then WAIT_DONE. i_tx_done in the START cycle is ignored.
- Pointer update: pointer becomes (k+1) mod p_REQUESTERS at every capture, including locked re-grants.
- WAIT_DONE: a 32-bit timeout counter increments each cycle.
  - i_tx_done = 1: go to GAP, or to the next-frame decision if p_GAP_CYCLES = 0.
  - Counter reaches p_TIMEOUT-1 without done: o_timeout pulses; go to GAP; lock count is cleared.
  - If done and timeout occur in the same cycle, done wins and there is no timeout pulse.
- GAP: holds p_GAP_CYCLES cycles. ov_grant stays on the owner; no new request is evaluated.
- Next-frame decision, at the end of the gap (or at done when the gap is 0):
  - Re-grant the same owner, bypassing round-robin, if all hold: iv_lock[k]=1, iv_req[k]=1, lock count < p_MAX_LOCK-1, and the frame did not time out.
  - Re-grant path: lock count increments; next cycle is START for k with a new ack.
  - Otherwise: lock count = 0, ov_grant = 0, state = IDLE. The IDLE arbitration happens one cycle later.
- Lock limit: p_MAX_LOCK = 1 disables locking.
- Requests: dropping a request without an ack is legal; it is simply not selected. A client's ack never coincides with its request being sampled twice for the same word.
- iv_lock is sampled only at the decision point.
- Acks: exactly one ov_ack bit pulses per o_tx_start; ov_ack is never asserted without o_tx_start.

Test Plan:
- Single client, N=4, data 0xA5 on client 2, GAP=2: o_tx_start and ack[2] arrive 1 cycle after the request; ov_tx_data = 0xA5; done after 20 cycles; o_busy stays high 2 more cycles, then IDLE with grant 0.
- Clients 0, 1, 3 requesting continuously, pointer 0: grant order 0, 1, 3, 0, 1, 3; each ack pulse is exactly 1 cycle; the gap between done and the next start is 3 cycles (2 gap + 1 IDLE).
- Client 1 with lock=1 and req=1, client 2 also requesting, MAX_LOCK=3: grants 1, 1, 1, 2. The re-grant start follows the gap end by 1 cycle (no IDLE cycle).
- No i_tx_done after start, TIMEOUT=100: o_timeout pulses once; the locked owner is not re-granted; the next requester is served.
- i_tx_done pulsed in the START cycle and again 5 cycles later: the first pulse is ignored; the frame ends on the second.
- i_rst asserted in WAIT_DONE and in GAP: the next cycle shows all outputs 0; after release, the first grant is client 0 when all clients request.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among several clients.
// It captures the winning client's word, pulses the transmitter start, waits for
// the frame-done pulse (bounded by a timeout), inserts an idle gap, and then
// either re-grants a locking client or returns to idle arbitration.
module uart_tx_scheduler #(
  parameter int p_REQUESTERS = 4,
  parameter int p_DATA_BITS  = 8,
  parameter int p_GAP_CYCLES = 2,
  parameter int p_MAX_LOCK   = 3,
  parameter int p_TIMEOUT    = 1000
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [p_REQUESTERS-1:0]               iv_req,
  input  logic [p_REQUESTERS-1:0]               iv_lock,
  input  logic [p_REQUESTERS*p_DATA_BITS-1:0]   iv_data,
  output logic [p_REQUESTERS-1:0]               ov_ack,
  output logic [p_REQUESTERS-1:0]               ov_grant,
  output logic [p_DATA_BITS-1:0]                ov_tx_data,
  output logic                                  o_tx_start,
  input  logic                                  i_tx_done,
  output logic                                  o_busy,
  output logic                                  o_timeout
);

  localparam int c_IW = (p_REQUESTERS > 1) ? $clog2(p_REQUESTERS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [c_IW-1:0] c_LAST     = c_IW'(p_REQUESTERS - 1);
  localparam logic [31:0]     c_TO_LAST  = 32'(p_TIMEOUT - 1);
  // With a zero gap this wraps to all ones, but the GAP state is never entered then.
  localparam logic [31:0]     c_GAP_LAST = 32'(p_GAP_CYCLES - 1);
  localparam logic [31:0]     c_LOCK_LIM = 32'(p_MAX_LOCK - 1);
  localparam bit              c_NO_GAP   = (p_GAP_CYCLES == 0);

  logic [1:0]              r_state;
  logic [c_IW-1:0]         r_ptr;
  logic [c_IW-1:0]         r_owner;
  logic [31:0]             r_cnt;
  logic [31:0]             r_lock_cnt;
  logic                    r_timed_out;
  logic [p_REQUESTERS-1:0] r_ack;
  logic [p_REQUESTERS-1:0] r_grant;
  logic [p_DATA_BITS-1:0]  r_tx_data;
  logic                    r_tx_start;
  logic                    r_timeout;

  logic [p_DATA_BITS-1:0]  w_words [p_REQUESTERS];
  logic                    w_found;
  logic [c_IW-1:0]         w_sel;
  logic [c_IW-1:0]         w_scan_idx;
  logic                    w_regrant;
  logic                    w_decide;
  logic                    w_to_hit;
  logic                    w_capture;
  logic                    w_release;
  logic [c_IW-1:0]         w_cap_idx;
  logic [p_REQUESTERS-1:0] w_cap_hot;
  logic [c_IW-1:0]         w_next_ptr;

  // Split the packed client bus into one word per client.
  always_comb begin
    for (int i = 0; i < p_REQUESTERS; i++) begin
      w_words[i] = iv_data[i*p_DATA_BITS +: p_DATA_BITS];
    end
  end

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_scan_idx = '0;
    for (int i = 0; i < p_REQUESTERS; i++) begin
      w_scan_idx = c_IW'((int'(r_ptr) + i) % p_REQUESTERS);
      if (!w_found && iv_req[w_scan_idx]) begin
        w_found = 1'b1;
        w_sel   = w_scan_idx;
      end else begin
        w_found = w_found;
        w_sel   = w_sel;
      end
    end
  end

  // End-of-frame decision terms and the shared capture index / one-hot.
  always_comb begin
    w_to_hit  = (r_state == S_WAIT) && !i_tx_done && (r_cnt == c_TO_LAST);
    w_decide  = ((r_state == S_GAP) && (r_cnt == c_GAP_LAST)) ||
                ((r_state == S_WAIT) && i_tx_done && c_NO_GAP);
    w_regrant = iv_lock[r_owner] && iv_req[r_owner] &&
                (r_lock_cnt < c_LOCK_LIM) && !r_timed_out;
    w_capture = ((r_state == S_IDLE) && w_found) || (w_decide && w_regrant);
    w_release = (w_decide && !w_regrant) || (w_to_hit && c_NO_GAP);
    w_cap_idx = (r_state == S_IDLE) ? w_sel : r_owner;
    w_cap_hot = '0;
    w_cap_hot[w_cap_idx] = 1'b1;
    w_next_ptr = (w_cap_idx == c_LAST) ? '0 : (w_cap_idx + 1'b1);
  end

  // Capture path: owner, grant, ack/start pulses, transmit word and pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner    <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_ptr      <= '0;
    end else begin
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      if (w_capture) begin
        r_owner    <= w_cap_idx;
        r_grant    <= w_cap_hot;
        r_ack      <= w_cap_hot;
        r_tx_start <= 1'b1;
        r_tx_data  <= w_words[w_cap_idx];
        r_ptr      <= w_next_ptr;
      end else if (w_release) begin
        r_grant <= '0;
      end
    end
  end

  // Frame sequencing: state, shared wait/gap counter, timeout and lock tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_lock_cnt  <= '0;
      r_timed_out <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_state     <= S_START;
            r_timed_out <= 1'b0;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
        S_WAIT: begin
          if (i_tx_done) begin
            r_cnt <= '0;
            if (c_NO_GAP) begin
              r_state    <= w_regrant ? S_START : S_IDLE;
              r_lock_cnt <= w_regrant ? (r_lock_cnt + 32'd1) : 32'd0;
            end else begin
              r_state <= S_GAP;
            end
          end else if (w_to_hit) begin
            r_timeout   <= 1'b1;
            r_timed_out <= 1'b1;
            r_lock_cnt  <= '0;
            r_cnt       <= '0;
            r_state     <= c_NO_GAP ? S_IDLE : S_GAP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_cnt      <= '0;
            r_state    <= w_regrant ? S_START : S_IDLE;
            r_lock_cnt <= w_regrant ? (r_lock_cnt + 32'd1) : 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ov_ack     = r_ack;
  assign ov_grant   = r_grant;
  assign ov_tx_data = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_timeout  = r_timeout;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: expected grants are queued when
// requests are driven and popped when the scheduler issues a start pulse.
module tb_uart_tx_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  iv_req;
  logic [3:0]  iv_lock;
  logic [31:0] iv_data;
  logic [3:0]  ov_ack;
  logic [3:0]  ov_grant;
  logic [7:0]  ov_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_timeout;

  typedef struct {
    int         client;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  uart_tx_scheduler #(
    .p_REQUESTERS(4), .p_DATA_BITS(8), .p_GAP_CYCLES(2),
    .p_MAX_LOCK(3), .p_TIMEOUT(100)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .iv_req(iv_req), .iv_lock(iv_lock),
    .iv_data(iv_data), .ov_ack(ov_ack), .ov_grant(ov_grant),
    .ov_tx_data(ov_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Every ack must come with a start pulse and match the one-hot grant.
  always @(negedge i_clk) begin
    if (o_tx_start === 1'b1 || ov_ack !== 4'b0000) begin
      n_vec++;
      if (o_tx_start !== 1'b1 || ov_ack !== ov_grant || $countones(ov_ack) != 1) begin
        n_err++;
        $display("FAIL ack_start_pair: ack=%b grant=%b start=%b, required one-hot ack equal to grant with start=1",
                 ov_ack, ov_grant, o_tx_start);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_done();
    i_tx_done = 1'b1;
    step(1);
    i_tx_done = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int cycles, output bit found);
    cycles = 0;
    found  = (o_tx_start === 1'b1);
    while (!found && cycles < budget) begin
      step(1);
      cycles++;
      found = (o_tx_start === 1'b1);
    end
  endtask

  function automatic logic [7:0] word_of(input logic [31:0] bus, input int k);
    return bus[k*8 +: 8];
  endfunction

  task automatic test_reset();
    i_rst = 1'b1; iv_req = 4'b0; iv_lock = 4'b0; i_tx_done = 1'b0;
    iv_data = {8'hC3, 8'hA5, 8'h3C, 8'h0F};
    step(2);
    n_vec++;
    if ({ov_ack, ov_grant, ov_tx_data, o_tx_start, o_busy, o_timeout} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: ack=%b grant=%b data=%h start=%b busy=%b to=%b, required all 0",
               ov_ack, ov_grant, ov_tx_data, o_tx_start, o_busy, o_timeout);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_single();
    int cyc; bit found; exp_t e;
    sb.push_back('{2, 8'hA5});
    iv_req = 4'b0100;
    wait_start(5, cyc, found);
    n_vec++;
    if (!found || cyc != 1) begin
      n_err++;
      $display("FAIL single_latency: found=%0d cycles=%0d, required start after 1 cycle", found, cyc);
    end
    e = sb.pop_front();
    n_vec++;
    if (ov_ack !== (4'b0001 << e.client) || ov_grant !== (4'b0001 << e.client) || ov_tx_data !== e.data) begin
      n_err++;
      $display("FAIL single_capture: ack=%b grant=%b data=%h, required client %0d data %h",
               ov_ack, ov_grant, ov_tx_data, e.client, e.data);
    end
    iv_req = 4'b0000;
    step(20);
    pulse_done();
    step(1);
    n_vec++;
    if (o_busy !== 1'b1 || ov_grant !== 4'b0100 || ov_tx_data !== 8'hA5) begin
      n_err++;
      $display("FAIL single_gap: busy=%b grant=%b data=%h, required busy=1 grant=0100 data=a5",
               o_busy, ov_grant, ov_tx_data);
    end
    step(1);
    n_vec++;
    if (o_busy !== 1'b0 || ov_grant !== 4'b0000) begin
      n_err++;
      $display("FAIL single_idle: busy=%b grant=%b, required busy=0 grant=0000", o_busy, ov_grant);
    end
  endtask

  task automatic test_round_robin();
    int cyc; bit found; exp_t e;
    int order[6] = '{0, 1, 3, 0, 1, 3};
    i_rst = 1'b1; step(1); i_rst = 1'b0;
    for (int f = 0; f < 6; f++) sb.push_back('{order[f], word_of(iv_data, order[f])});
    iv_req = 4'b1011;
    for (int f = 0; f < 6; f++) begin
      wait_start(10, cyc, found);
      e = sb.pop_front();
      n_vec++;
      // After the done-pulse cycle: two gap cycles then one idle cycle.
      if (!found || cyc != ((f == 0) ? 1 : 3)) begin
        n_err++;
        $display("FAIL rr_latency frame %0d: found=%0d cycles=%0d, required %0d", f, found, cyc, (f == 0) ? 1 : 3);
      end
      n_vec++;
      if (ov_ack !== (4'b0001 << e.client) || ov_tx_data !== e.data) begin
        n_err++;
        $display("FAIL rr_order frame %0d: ack=%b data=%h, required client %0d data %h",
                 f, ov_ack, ov_tx_data, e.client, e.data);
      end
      if (f == 5) iv_req = 4'b0000;
      step(1);
      n_vec++;
      if (ov_ack !== 4'b0000 || o_tx_start !== 1'b0) begin
        n_err++;
        $display("FAIL rr_ack_width frame %0d: ack=%b start=%b, required 0000/0", f, ov_ack, o_tx_start);
      end
      step(2);
      pulse_done();
    end
    step(2);
    n_vec++;
    if (o_busy !== 1'b0 || ov_grant !== 4'b0000) begin
      n_err++;
      $display("FAIL rr_idle: busy=%b grant=%b, required 0/0000", o_busy, ov_grant);
    end
  endtask

  task automatic test_lock();
    int cyc; bit found; exp_t e;
    logic [7:0] lw[3] = '{8'h11, 8'h22, 8'h33};
    int exp_cyc[4] = '{1, 2, 2, 3};
    i_rst = 1'b1; step(1); i_rst = 1'b0;
    iv_data[15:8] = lw[0];
    sb.push_back('{1, lw[0]});
    iv_req = 4'b0110; iv_lock = 4'b0010;
    for (int f = 0; f < 4; f++) begin
      wait_start(10, cyc, found);
      e = sb.pop_front();
      n_vec++;
      if (!found || cyc != exp_cyc[f]) begin
        n_err++;
        $display("FAIL lock_latency frame %0d: found=%0d cycles=%0d, required %0d", f, found, cyc, exp_cyc[f]);
      end
      n_vec++;
      if (ov_ack !== (4'b0001 << e.client) || ov_tx_data !== e.data) begin
        n_err++;
        $display("FAIL lock_order frame %0d: ack=%b data=%h, required client %0d data %h",
                 f, ov_ack, ov_tx_data, e.client, e.data);
      end
      if (f < 2) begin
        iv_data[15:8] = lw[f+1];
        sb.push_back('{1, lw[f+1]});
      end else if (f == 2) begin
        sb.push_back('{2, word_of(iv_data, 2)});
      end else begin
        iv_req = 4'b0000; iv_lock = 4'b0000;
      end
      step(3);
      pulse_done();
    end
    step(2);
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL lock_idle: busy=%b, required 0", o_busy);
    end
  endtask

  task automatic test_timeout();
    int cyc; bit found; exp_t e; int t;
    i_rst = 1'b1; step(1); i_rst = 1'b0;
    sb.push_back('{0, word_of(iv_data, 0)});
    sb.push_back('{1, word_of(iv_data, 1)});
    iv_req = 4'b0011; iv_lock = 4'b0001;
    wait_start(5, cyc, found);
    e = sb.pop_front();
    n_vec++;
    if (!found || ov_ack !== (4'b0001 << e.client)) begin
      n_err++;
      $display("FAIL to_first: found=%0d ack=%b, required client %0d", found, ov_ack, e.client);
    end
    t = 0;
    while (o_timeout !== 1'b1 && t < 150) begin
      step(1);
      t++;
    end
    // One START cycle plus 100 waiting cycles, pulse visible on the next.
    n_vec++;
    if (t != 101) begin
      n_err++;
      $display("FAIL to_delay: timeout after %0d cycles, required 101", t);
    end
    step(1);
    n_vec++;
    if (o_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL to_pulse_width: timeout=%b, required 0", o_timeout);
    end
    wait_start(5, cyc, found);
    e = sb.pop_front();
    n_vec++;
    if (!found || cyc != 2 || ov_ack !== (4'b0001 << e.client) || ov_tx_data !== e.data) begin
      n_err++;
      $display("FAIL to_next_owner: found=%0d cycles=%0d ack=%b data=%h, required client %0d after 2 cycles",
               found, cyc, ov_ack, ov_tx_data, e.client);
    end
    iv_req = 4'b0000; iv_lock = 4'b0000;
    step(2);
    pulse_done();
    step(2);
  endtask

  task automatic test_done_in_start();
    int cyc; bit found;
    i_rst = 1'b1; step(1); i_rst = 1'b0;
    iv_req = 4'b1000;
    wait_start(5, cyc, found);
    n_vec++;
    if (!found || ov_grant !== 4'b1000 || ov_tx_data !== 8'hC3) begin
      n_err++;
      $display("FAIL dis_start: found=%0d grant=%b data=%h, required 1000/c3", found, ov_grant, ov_tx_data);
    end
    iv_req = 4'b0000;
    pulse_done();
    step(4);
    n_vec++;
    if (o_busy !== 1'b1 || ov_grant !== 4'b1000) begin
      n_err++;
      $display("FAIL dis_ignored: busy=%b grant=%b, required 1/1000", o_busy, ov_grant);
    end
    pulse_done();
    step(1);
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL dis_gap: busy=%b, required 1", o_busy);
    end
    step(1);
    n_vec++;
    if (o_busy !== 1'b0 || ov_grant !== 4'b0000) begin
      n_err++;
      $display("FAIL dis_end: busy=%b grant=%b, required 0/0000", o_busy, ov_grant);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit found; exp_t e;
    i_rst = 1'b1; step(1); i_rst = 1'b0;
    iv_req = 4'b1111;
    for (int phase = 0; phase < 3; phase++) begin
      sb.push_back('{0, word_of(iv_data, 0)});
      wait_start(5, cyc, found);
      e = sb.pop_front();
      n_vec++;
      if (!found || cyc != 1 || ov_ack !== (4'b0001 << e.client) || ov_tx_data !== e.data) begin
        n_err++;
        $display("FAIL rst_first_grant phase %0d: found=%0d cycles=%0d ack=%b data=%h, required client 0 data %h",
                 phase, found, cyc, ov_ack, ov_tx_data, e.data);
      end
      if (phase == 2) break;
      step(3);
      if (phase == 1) pulse_done();
      i_rst = 1'b1;
      step(1);
      n_vec++;
      if ({ov_ack, ov_grant, ov_tx_data, o_tx_start, o_busy, o_timeout} !== 19'd0) begin
        n_err++;
        $display("FAIL rst_mid phase %0d: ack=%b grant=%b data=%h start=%b busy=%b to=%b, required all 0",
                 phase, ov_ack, ov_grant, ov_tx_data, o_tx_start, o_busy, o_timeout);
      end
      i_rst = 1'b0;
    end
    iv_req = 4'b0000;
    step(2);
    pulse_done();
    step(2);
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_final_idle: busy=%b, required 0", o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_done_in_start();
    test_reset_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
